k_fifo_2deep_ctrl: RTL

Controller that turns the 2-entry dual-port RAM macro into a valid/ready FIFO. It owns the RAM's write-enable and both addresses, arbitrates the RAM's single access slot between pushes and reads, and re-registers RAM output into a show-ahead output stage. It sits between an upstream producer and a downstream consumer; the RAM itself is instantiated beside it at the FIFO top level.

---
 rtl/k_fifo_2deep_ctrl_pkg.sv | 27 ++
 rtl/k_fifo_2deep_ctrl_if.sv | 28 ++
 rtl/k_fifo_2deep_ctrl_rr_arb.sv | 44 ++++
 rtl/k_fifo_2deep_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/k_fifo_2deep_ctrl_pkg.sv
// ============================================================================
// k_fifo_pkg : shared types and constants for the 2-deep RAM FIFO controller
// Rev 1.0
// ============================================================================
`default_nettype none

package k_fifo_pkg;

  typedef enum logic {
    GNT_W = 1'b0,
    GNT_R = 1'b1
  } grant_e;

  localparam int RAM_DEPTH = 2;
  localparam int PTR_W     = 1;
  localparam int LEVEL_W   = 2;
  localparam int CNT_W     = 2;

  localparam logic [CNT_W-1:0] C_CNT_FULL = CNT_W'(RAM_DEPTH);

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(RAM_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/k_fifo_2deep_ctrl_if.sv
// ============================================================================
// k_fifo_2deep_ctrl_if : producer/consumer valid-ready bundle of the FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

interface k_fifo_2deep_ctrl_if #(
  parameter int DATA_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );
endinterface

`default_nettype wire

// File: rtl/k_fifo_2deep_ctrl_rr_arb.sv
// ============================================================================
// k_fifo_rr_arb : 2-way round-robin between RAM write and RAM read requests
// Rev 1.0
// ============================================================================
`default_nettype none

module k_fifo_rr_arb
  import k_fifo_pkg::*;
(
  input  wire logic clk,
  input  wire logic rst_n,
  input  wire logic req_w,
  input  wire logic req_r,
  output logic      gnt_w,
  output logic      gnt_r,
  output grant_e    rr_last
);

  grant_e rr_last_q;
  grant_e rr_last_d;

  // On contention the side that did not win last time gets the slot.
  always_comb begin
    gnt_w     = req_w && !(req_r && (rr_last_q == GNT_W));
    gnt_r     = req_r && !(req_w && (rr_last_q == GNT_R));
    rr_last_d = rr_last_q;
    if (req_w && req_r) begin
      rr_last_d = gnt_w ? GNT_W : GNT_R;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q <= GNT_R;
    end else begin
      rr_last_q <= rr_last_d;
    end
  end

  assign rr_last = rr_last_q;

endmodule

`default_nettype wire

// File: rtl/k_fifo_2deep_ctrl.sv
// ============================================================================
// k_fifo_2deep_ctrl : drives a 2-entry dual-port RAM as a show-ahead FIFO
// Rev 1.0
// ============================================================================
`default_nettype none

module k_fifo_2deep_ctrl
  import k_fifo_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  wire logic                clk,
  input  wire logic                rst_n,
  k_fifo_2deep_ctrl_if.slave       fifo,
  output logic [LEVEL_W-1:0]       level,
  output logic                     ram_wen,
  output logic [PTR_W-1:0]         ram_waddr,
  output logic [PTR_W-1:0]         ram_raddr,
  output logic [DATA_W-1:0]        ram_d,
  input  wire logic [DATA_W-1:0]   ram_q
);

  logic [PTR_W-1:0]  wptr_q, wptr_d;
  logic [PTR_W-1:0]  rptr_q, rptr_d;
  logic [PTR_W-1:0]  raddr_q, raddr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              inflight_q, inflight_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;

  logic   rd_req;
  logic   req_w;
  logic   push;
  logic   rd_issue;
  grant_e rr_last;

  assign rd_req = (cnt_q != '0) && !inflight_q && (!out_valid_q || fifo.out_ready);
  assign req_w  = fifo.in_valid && (cnt_q != C_CNT_FULL);

  k_fifo_rr_arb u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .req_w   (req_w),
    .req_r   (rd_req),
    .gnt_w   (push),
    .gnt_r   (rd_issue),
    .rr_last (rr_last)
  );

  // Ready is advertised without looking at in_valid, so it must assume a
  // write would contend with any pending read.
  assign fifo.in_ready = (cnt_q != C_CNT_FULL) && !(rd_req && (rr_last == GNT_W));

  always_comb begin
    wptr_d      = wptr_q;
    rptr_d      = rptr_q;
    raddr_d     = raddr_q;
    cnt_d       = cnt_q;
    inflight_d  = 1'b0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;

    if (push) begin
      wptr_d = ptr_inc(wptr_q);
      cnt_d  = cnt_q + 1'b1;
    end else if (rd_issue) begin
      rptr_d     = ptr_inc(rptr_q);
      raddr_d    = rptr_q;
      cnt_d      = cnt_q - 1'b1;
      inflight_d = 1'b1;
    end

    // RAM q is held across write cycles, so a capture is safe next to a push.
    if (inflight_q) begin
      out_data_d  = ram_q;
      out_valid_d = 1'b1;
    end else if (out_valid_q && fifo.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q      <= '0;
      rptr_q      <= '0;
      raddr_q     <= '0;
      cnt_q       <= '0;
      inflight_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wptr_q      <= wptr_d;
      rptr_q      <= rptr_d;
      raddr_q     <= raddr_d;
      cnt_q       <= cnt_d;
      inflight_q  <= inflight_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  assign ram_wen        = push;
  assign ram_waddr      = wptr_q;
  assign ram_raddr      = rd_issue ? rptr_q : raddr_q;
  assign ram_d          = fifo.in_data;
  assign fifo.out_valid = out_valid_q;
  assign fifo.out_data  = out_data_q;
  assign level          = LEVEL_W'(cnt_q) + LEVEL_W'(inflight_q) + LEVEL_W'(out_valid_q);

endmodule

`default_nettype wire
